// File: rtl/ad_frame_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ad_frame_fifo_if
//  Brief    : Capture strobe/data and lbs register-window bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface ad_frame_fifo_if;
   logic [127:0] ad_dat;
   logic         ad_vld;
   logic [7:0]   lbs_addr;
   logic [7:0]   lbs_din;
   logic [7:0]   lbs_dout;
   logic         lbs_we;
   logic         lbs_re;
   logic         lbs_cs_n;
   logic         int_o;

   modport master (
      output ad_dat, ad_vld, lbs_addr, lbs_din, lbs_we, lbs_re, lbs_cs_n,
      input  lbs_dout, int_o
   );

   modport slave (
      input  ad_dat, ad_vld, lbs_addr, lbs_din, lbs_we, lbs_re, lbs_cs_n,
      output lbs_dout, int_o
   );
endinterface
`default_nettype wire

// File: rtl/ad_frame_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ad_frame_fifo
//  Brief    : Frame-deep FIFO of AD7606 8x16-bit frames, drained bytewise over
//             an 8-bit lbs register window. Optional AD_FRAME_TS_EN adds a
//             32-bit capture timestamp per frame (regs 0x06..0x09).
//  Revision : 1.0 - initial release
// ============================================================================
module ad_frame_fifo #(
   parameter int FRAME_DEPTH = 16,
   parameter int AW          = 4,
   parameter int U_DLY       = 1
) (
   input wire             clk,
   input wire             rst_n,
   ad_frame_fifo_if.slave bus
);

   generate
      if (((1 << AW) != FRAME_DEPTH) || (FRAME_DEPTH < 2) || (FRAME_DEPTH > 64) || (U_DLY < 0)) begin : g_bad_cfg
         $error("ad_frame_fifo: FRAME_DEPTH must equal 2**AW and lie in 2..64");
      end
   endgenerate

`ifdef AD_FRAME_TS_EN
   localparam int c_ew = 160;
`else
   localparam int c_ew = 128;
`endif
   localparam logic [7:0] c_a_ctrl   = 8'h00;
   localparam logic [7:0] c_a_thresh = 8'h01;
   localparam logic [7:0] c_a_status = 8'h02;
   localparam logic [7:0] c_a_level  = 8'h03;
   localparam logic [7:0] c_a_dat_l  = 8'h04;
   localparam logic [7:0] c_a_dat_h  = 8'h05;
   localparam logic [7:0] c_depth8   = 8'(FRAME_DEPTH);
   localparam logic [AW:0] c_depth   = FRAME_DEPTH[AW:0];
   localparam logic [AW:0] c_one     = {{AW{1'b0}}, 1'b1};

   logic [c_ew-1:0] r_mem [FRAME_DEPTH];
   logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [AW:0]     r_level, r_thresh;
   logic [2:0]      r_word_idx;
   logic            r_cap_en, r_int_en, r_ovf, r_int;
   logic [7:0]      r_shadow, r_dout;

   logic            w_rd, w_wr, w_empty, w_full, w_clr, w_push, w_pop, w_ovf_set, w_pend;
   logic            w_rd_l, w_rd_h;
   logic [c_ew-1:0] w_head, w_entry;
   logic [15:0]     w_word;
   logic [7:0]      w_rd_data;
   logic [AW:0]     w_thresh_sat;

   assign w_rd      = bus.lbs_re & ~bus.lbs_cs_n;
   assign w_wr      = bus.lbs_we & ~bus.lbs_cs_n;
   assign w_empty   = (r_level == '0);
   assign w_full    = (r_level == c_depth);
   assign w_pend    = (r_level >= r_thresh);
   assign w_clr     = w_wr & (bus.lbs_addr == c_a_ctrl) & bus.lbs_din[1];
   // A clear in the same cycle takes precedence over both capture and overflow
   assign w_push    = bus.ad_vld & r_cap_en & ~w_full & ~w_clr;
   assign w_ovf_set = bus.ad_vld & r_cap_en & w_full & ~w_clr;
   assign w_rd_l    = w_rd & (bus.lbs_addr == c_a_dat_l) & ~w_empty;
   assign w_rd_h    = w_rd & (bus.lbs_addr == c_a_dat_h) & ~w_empty;
   assign w_pop     = w_rd_h & (r_word_idx == 3'd7);
   assign w_head    = r_mem[r_rd_ptr];
   assign w_word    = w_head[{r_word_idx, 4'b0000} +: 16];

   assign bus.lbs_dout = r_dout;
   assign bus.int_o    = r_int;

`ifdef AD_FRAME_TS_EN
   logic [31:0] r_ts_cnt, r_ts_snap;
   assign w_entry = {r_ts_cnt, bus.ad_dat};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ts_cnt  <= 32'h0;
         r_ts_snap <= 32'h0;
      end else begin
         r_ts_cnt <= r_ts_cnt + 32'h1;
         // Snapshot on the low byte so bytes 1..3 match it even if the head moves
         if (w_rd && (bus.lbs_addr == 8'h06))
            r_ts_snap <= w_empty ? 32'h0 : w_head[159:128];
      end
   end
`else
   assign w_entry = bus.ad_dat;
`endif

   always_comb begin
      w_thresh_sat = bus.lbs_din[AW:0];
      if (bus.lbs_din == 8'h00)
         w_thresh_sat = c_one;
      else if (bus.lbs_din > c_depth8)
         w_thresh_sat = c_depth;
   end

   always_comb begin
      w_rd_data = 8'h00;
      case (bus.lbs_addr)
         c_a_ctrl:   w_rd_data = {5'b0, r_int_en, 1'b0, r_cap_en};
         c_a_thresh: w_rd_data = 8'(r_thresh);
         c_a_status: w_rd_data = {4'b0, w_pend, r_ovf, w_full, w_empty};
         c_a_level:  w_rd_data = 8'(r_level);
         c_a_dat_l:  w_rd_data = w_empty ? 8'h00 : w_word[7:0];
         c_a_dat_h:  w_rd_data = w_empty ? 8'h00 : r_shadow;
`ifdef AD_FRAME_TS_EN
         8'h06:      w_rd_data = w_empty ? 8'h00 : w_head[135:128];
         8'h07:      w_rd_data = r_ts_snap[15:8];
         8'h08:      w_rd_data = r_ts_snap[23:16];
         8'h09:      w_rd_data = r_ts_snap[31:24];
`endif
         default:    w_rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_word_idx <= 3'd0;
         r_thresh   <= c_one;
         r_cap_en   <= 1'b0;
         r_int_en   <= 1'b0;
         r_ovf      <= 1'b0;
         r_int      <= 1'b0;
         r_shadow   <= 8'h00;
         r_dout     <= 8'h00;
      end else begin
         r_int <= r_int_en & w_pend;
         if (w_rd)
            r_dout <= w_rd_data;
         if (w_wr && (bus.lbs_addr == c_a_ctrl)) begin
            r_cap_en <= bus.lbs_din[0];
            r_int_en <= bus.lbs_din[2];
         end
         if (w_wr && (bus.lbs_addr == c_a_thresh))
            r_thresh <= w_thresh_sat;
         if (w_rd_l)
            r_shadow <= w_word[15:8];

         if (w_clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_word_idx <= 3'd0;
            r_ovf      <= 1'b0;
            r_shadow   <= 8'h00;
         end else begin
            if (w_push)
               r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + 1'b1;
            // The 3-bit index wraps 7 -> 0 exactly when the frame pops
            if (w_rd_h)
               r_word_idx <= r_word_idx + 3'd1;
            case ({w_push, w_pop})
               2'b10:   r_level <= r_level + c_one;
               2'b01:   r_level <= r_level - c_one;
               default: r_level <= r_level;
            endcase
            if (w_ovf_set)
               r_ovf <= 1'b1;
            else if (w_wr && (bus.lbs_addr == c_a_status) && bus.lbs_din[2])
               r_ovf <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/ad_frame_fifo.md
Name: ad_frame_fifo

Overview:
- Sample buffer between the AD7606 capture stage and the DSP local-bus slave decoder.
- Captures each complete 8-channel conversion frame (8 x 16 bit) into a frame-deep FIFO.
- The DSP drains the FIFO byte-wise through an 8-bit lbs-style register window.
- Raises a level interrupt when the stored frame count reaches a programmable threshold.

Parameters:
- FRAME_DEPTH, 16, number of 128-bit frames stored; power of two, 2..64.
- AW, 4, log2(FRAME_DEPTH).
- U_DLY, 1, register assignment delay for simulation.

Ports:
- clk  in  1  system clock, 80 MHz domain.
- rst_n  in  1  asynchronous active-low reset.
- ad_dat  in  128  frame data; chn0 at [15:0] ... chn7 at [127:112].
- ad_vld  in  1  one-cycle strobe; ad_dat is valid and complete in that cycle.
- lbs_addr  in  8  register address.
- lbs_din  in  8  write data.
- lbs_dout  out  8  read data.
- lbs_we  in  1  write strobe, one cycle, qualified by lbs_cs_n=0.
- lbs_re  in  1  read strobe, one cycle, qualified by lbs_cs_n=0.
- lbs_cs_n  in  1  chip select, active low.
- int_o  out  1  level interrupt to the sys_registers interrupt collector.

Behaviour:
- Reset values: lbs_dout=0x00, int_o=0, all pointers/level/index=0, CTRL=0x00, THRESH=0x01, overflow=0.
- Register map:
  - 0x00 CTRL, R/W:
    - bit0 cap_en.
    - bit1 clr: self-clearing, reads 0.
    - bit2 int_en.
  - 0x01 THRESH, R/W: values 0 and >FRAME_DEPTH saturate to 1 and FRAME_DEPTH respectively on write.
  - 0x02 STATUS, R; W1C on bit2:
    - bit0 empty.
    - bit1 full.
    - bit2 ovf (sticky).
    - bit3 int pending (level>=THRESH).
  - 0x03 LEVEL, R: frames stored, 0..FRAME_DEPTH.
  - 0x04 DATA_L, R: low byte of current word; latches the high byte into a shadow register.
  - 0x05 DATA_H, R: shadow byte; advances the word index.
  - Unmapped addresses read 0x00; writes to them are ignored.
- Read timing: lbs_dout is registered, updates the cycle after lbs_re&~lbs_cs_n, and holds until the next read.
- Push:
  - ad_vld & cap_en & ~full: frame written at wr_ptr; wr_ptr++ (mod FRAME_DEPTH).
  - ad_vld while cap_en=0: ignored, no flag.
  - ad_vld & cap_en & full: frame dropped, ovf<=1, pointers unchanged.
- Pop sequencing:
  - word_idx 0..7 selects the 16-bit channel of the head frame.
  - A DATA_H read with word_idx=7 pops the frame: rd_ptr++, word_idx<=0.
  - Otherwise a DATA_H read does word_idx++.
  - DATA_L/DATA_H reads while empty return 0x00 and do not move any pointer.
- Simultaneous push and pop in the same cycle: level unchanged, both pointers advance.
- Level: binary counter, AW+1 bits; full = (level==FRAME_DEPTH); empty = (level==0).
- clr=1:
  - In the write cycle: pointers, level, word_idx and ovf <= 0.
  - A concurrent push in that cycle is discarded.
  - A partially read frame is lost.
- ovf W1C vs. a new overflow in the same cycle: the set wins.
- int_o is registered: int_o <= int_en & (level>=THRESH); one cycle of latency after the level or THRESH change.
- Storage: 128-bit x FRAME_DEPTH array, written in one cycle. Read is a combinational mux on rd_ptr/word_idx into the registered lbs_dout.

Optional Feature:
- Macro AD_FRAME_TS_EN.
- When defined:
  - A 32-bit free-running cycle counter (reset 0, wraps) is stored alongside each pushed frame, in a 160-bit entry.
  - 0x06..0x09 read timestamp bytes [7:0]..[31:24] of the head frame.
  - These reads never advance pointers.
  - A read of 0x06 snapshots the whole 32-bit value so the bytes are coherent.
- When not defined: 0x06..0x09 read 0x00; no counter or extra storage is synthesised.

Test Plan:
- Reset, then read 0x00..0x05 -> 0x00, 0x01, 0x01 (empty), 0x00, 0x00, 0x00; int_o=0.
- cap_en=1, push one frame with chn0=0x1234, chn7=0xBEEF, then 8x(DATA_L, DATA_H):
  - -> first pair 0x34, 0x12; last pair 0xEF, 0xBE.
  - -> LEVEL 1 before the pop, 0 after it; STATUS=0x01.
- Push 17 frames with FRAME_DEPTH=16:
  - -> LEVEL=16, STATUS=0x0E with int_en=1 and THRESH=16, int_o=1.
  - Write 0x04 to 0x02 -> ovf clears, STATUS=0x0A.
- THRESH=3, int_en=1, push 2 frames -> int_o=0; push a 3rd -> int_o=1 one cycle after LEVEL=3; fully read one frame -> int_o=0.
- ad_vld in the same cycle as the DATA_H read that pops frame word 7, with LEVEL=5 -> LEVEL stays 5, data order preserved.
- Read 3 words, write CTRL=0x03 with ad_vld in the same cycle -> LEVEL=0, STATUS=0x01. The next push and read returns the new frame from word 0.
